// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the parallel-in/serial-out transmit path.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  // Bit-counter width for a word of the given size; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/bit_counter.sv
// Up-counter with synchronous clear, enable and a terminal-count flag at MAX.
module bit_counter #(
  parameter int unsigned MAX   = 7,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  assign tc = (cnt == CNT_W'(MAX));

  // Saturates at MAX so a word never wraps; clear has priority over count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/piso_shifter.sv
// Parallel-in/serial-out transmitter: accepts a word on load/ready and shifts it
// out one bit per clock, with back-to-back words accepted on the last bit.
module piso_shifter
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             done
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  piso_state_t      state_q;
  piso_state_t      state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic [WIDTH-1:0] shreg_next;
  logic [CNT_W-1:0] cnt;
  logic             tc;
  logic             accept;
  logic             cnt_clr;
  logic             cnt_en;

  bit_counter #(
    .MAX   (WIDTH - 1),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .cnt (cnt),
    .tc  (tc)
  );

  // Next transmit bit moves into the output position.
  assign shreg_next = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                : {1'b0, shreg_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
    end
  end

  // Ready depends only on state and counter, never on load.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    ready   = rst && ((state_q == IDLE) || tc);
    accept  = load && ready;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          shreg_d = data_in;
          cnt_clr = 1'b1;
        end
      end
      SHIFT: begin
        if (accept) begin
          shreg_d = data_in;
          cnt_clr = 1'b1;
        end else begin
          shreg_d = shreg_next;
          cnt_en  = 1'b1;
          if (tc) begin
            state_d = IDLE;
            cnt_clr = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign serial_valid = (state_q == SHIFT);
  assign serial_out   = (state_q == SHIFT) &&
                        (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);
  assign done         = (state_q == SHIFT) && tc;

endmodule

// File: tb/tb_piso_shifter.sv
// Directed and table-driven bench for piso_shifter (MSB-first and LSB-first instances).
module tb_piso_shifter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_m, data_l;
  logic       load_m, load_l;
  logic       ready_m, so_m, sv_m, done_m;
  logic       ready_l, so_l, sv_l, done_l;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  piso_shifter #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_m),
    .load         (load_m),
    .ready        (ready_m),
    .serial_out   (so_m),
    .serial_valid (sv_m),
    .done         (done_m)
  );

  piso_shifter #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_l),
    .load         (load_l),
    .ready        (ready_l),
    .serial_out   (so_l),
    .serial_valid (sv_l),
    .done         (done_l)
  );

  typedef struct {
    string      name;
    logic       lsb;
    logic [7:0] word;
    logic [7:0] exp_bits;  // transmit order, first bit in [7]
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic sel_so(input logic lsb);
    return lsb ? so_l : so_m;
  endfunction
  function automatic logic sel_sv(input logic lsb);
    return lsb ? sv_l : sv_m;
  endfunction
  function automatic logic sel_done(input logic lsb);
    return lsb ? done_l : done_m;
  endfunction
  function automatic logic sel_ready(input logic lsb);
    return lsb ? ready_l : ready_m;
  endfunction

  task automatic drive(input logic lsb, input logic ld, input logic [7:0] d);
    if (lsb) begin
      load_l = ld;
      data_l = d;
    end else begin
      load_m = ld;
      data_m = d;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated word starting from IDLE, checked bit by bit.
  task automatic run_vec(input vec_t v);
    drive(v.lsb, 1'b1, v.word);
    @(negedge clk);
    chk($sformatf("%s_ready_idle", v.name), 16'(sel_ready(v.lsb)), 16'h1);
    step();
    drive(v.lsb, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("%s_bit%0d", v.name, i), 16'(sel_so(v.lsb)), 16'(v.exp_bits[7-i]));
      chk($sformatf("%s_valid%0d", v.name, i), 16'(sel_sv(v.lsb)), 16'h1);
      chk($sformatf("%s_done%0d", v.name, i), 16'(sel_done(v.lsb)), 16'(i == 7));
      chk($sformatf("%s_ready%0d", v.name, i), 16'(sel_ready(v.lsb)), 16'(i == 7));
      step();
    end
    @(negedge clk);
    chk($sformatf("%s_valid_after", v.name), 16'(sel_sv(v.lsb)), 16'h0);
    chk($sformatf("%s_ready_after", v.name), 16'(sel_ready(v.lsb)), 16'h1);
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] stream;
    logic [7:0]  rx;
    logic [7:0]  words[50];
    int          rand_err;

    vecs[0] = '{name: "a5_msb", lsb: 1'b0, word: 8'hA5, exp_bits: 8'b10100101};
    vecs[1] = '{name: "01_lsb", lsb: 1'b1, word: 8'h01, exp_bits: 8'b10000000};
    vecs[2] = '{name: "3c_lsb", lsb: 1'b1, word: 8'h3C, exp_bits: 8'b00111100};
    vecs[3] = '{name: "80_lsb", lsb: 1'b1, word: 8'h80, exp_bits: 8'b00000001};
    vecs[4] = '{name: "e2_msb", lsb: 1'b0, word: 8'hE2, exp_bits: 8'b11100010};

    rst    = 1'b0;
    load_m = 1'b0; data_m = 8'h00;
    load_l = 1'b0; data_l = 8'h00;

    // Reset state
    #3;
    chk("rst_ready", 16'(ready_m), 16'h0);
    chk("rst_valid", 16'(sv_m), 16'h0);
    chk("rst_so", 16'(so_m), 16'h0);
    chk("rst_done", 16'(done_m), 16'h0);
    step();
    step();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rel_ready_m", 16'(ready_m), 16'h1);
    chk("rel_ready_l", 16'(ready_l), 16'h1);
    step();

    for (int v = 0; v < 5; v++) run_vec(vecs[v]);

    // Back-to-back: F0 then 0F with load held high
    stream = 16'hF00F;
    drive(1'b0, 1'b1, 8'hF0);
    step();
    data_m = 8'h0F;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk($sformatf("b2b_bit%0d", i), 16'(so_m), 16'(stream[15-i]));
      chk($sformatf("b2b_valid%0d", i), 16'(sv_m), 16'h1);
      chk($sformatf("b2b_done%0d", i), 16'(done_m), 16'((i == 7) || (i == 15)));
      step();
      if (i == 7) load_m = 1'b0;
    end
    @(negedge clk);
    chk("b2b_valid_after", 16'(sv_m), 16'h0);
    step();

    // Busy load ignored: FF presented during the third bit of C3
    drive(1'b0, 1'b1, 8'hC3);
    step();
    load_m = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 2) begin
        chk("busy_ready", 16'(ready_m), 16'h0);
        load_m = 1'b1;
        data_m = 8'hFF;
      end
      chk($sformatf("busy_bit%0d", i), 16'(so_m), 16'(8'hC3 >> (7 - i)) & 16'h1);
      chk($sformatf("busy_done%0d", i), 16'(done_m), 16'(i == 7));
      step();
      load_m = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("busy_idle%0d", i), 16'(sv_m), 16'h0);
      step();
    end

    // Reset after four bits of 3C
    drive(1'b0, 1'b1, 8'h3C);
    step();
    load_m = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("mid_bit%0d", i), 16'(so_m), 16'(8'h3C >> (7 - i)) & 16'h1);
      step();
    end
    rst = 1'b0;
    #1;
    chk("mid_so", 16'(so_m), 16'h0);
    chk("mid_valid", 16'(sv_m), 16'h0);
    chk("mid_done", 16'(done_m), 16'h0);
    chk("mid_ready", 16'(ready_m), 16'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("mid_hold_done%0d", i), 16'(done_m), 16'h0);
      chk($sformatf("mid_hold_valid%0d", i), 16'(sv_m), 16'h0);
    end
    rst = 1'b1;
    #1;
    chk("mid_rel_ready", 16'(ready_m), 16'h1);
    step();
    run_vec('{name: "81_after_rst", lsb: 1'b0, word: 8'h81, exp_bits: 8'b10000001});

    // 50 random words, back-to-back, through a deserializer
    rand_err = 0;
    for (int w = 0; w < 50; w++) words[w] = 8'($urandom_range(0, 255));
    drive(1'b0, 1'b1, words[0]);
    step();
    load_m = 1'b0;
    for (int w = 0; w < 50; w++) begin
      rx = 8'h00;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (!sv_m) rand_err++;
        if (done_m !== (i == 7)) rand_err++;
        rx = {rx[6:0], so_m};
        if (i == 7 && w < 49) begin
          load_m = 1'b1;
          data_m = words[w+1];
        end
        step();
        load_m = 1'b0;
      end
      if (rx !== words[w]) begin
        rand_err++;
        $display("FAIL rand_word%0d actual=%0h required=%0h", w, rx, words[w]);
      end
    end
    chk("rand_errors", 16'(rand_err), 16'h0);
    @(negedge clk);
    chk("rand_idle", 16'(sv_m), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/piso_shifter.md
# piso_shifter

Parallel-in/serial-out transmitter: the read-side counterpart of the `register` load path. Accepts a WIDTH-bit word through a valid/ready handshake and drives it out one bit per clock, MSB first by default. Supports back-to-back words with no idle bubble. Sits between a parallel holding register and a single-wire serial link or a downstream serial checker.

## Interface
- `WIDTH`, 8, word width in bits; must be at least 2.
- `MSB_FIRST`, 1, selects shift order: 1 sends bit WIDTH-1 first, 0 sends bit 0 first.

Ports:
- `clk`  input  1  single clock; all state updates on posedge.
- `rst`  input  1  reset; asynchronous, active-low (0 = reset asserted).
- `data_in`  input  WIDTH  parallel word; sampled only on an accepted load.
- `load`  input  1  word valid from upstream.
- `ready`  output  1  shifter can accept a word this cycle.
- `serial_out`  output  1  current serial bit.
- `serial_valid`  output  1  `serial_out` carries a data bit.
- `done`  output  1  one-cycle pulse coincident with the last bit of a word.

## Operation
- FSM, 2 states:
  - IDLE (reset state).
  - SHIFT.
- Accept condition: `load && ready` at a posedge.
  - Word is copied into the internal shift register.
  - Bit counter is cleared to 0.
  - State becomes SHIFT.
- `ready`:
  - Combinational.
  - 1 in IDLE.
  - 1 in SHIFT only when counter == WIDTH-1 (last bit).
  - 0 otherwise.
  - Forced 0 while `rst` = 0.
- In SHIFT, each posedge without an accept:
  - Shift register shifts by one (toward MSB when MSB_FIRST=1, toward LSB when MSB_FIRST=0).
  - Counter increments.
  - When counter == WIDTH-1 and there is no accept, the next state is IDLE.
- Last-bit accept (counter == WIDTH-1 and `load`): the new word is loaded, the counter goes to 0, and the state stays SHIFT. No gap between words.
- `load` while `ready` = 0: ignored; `data_in` is not sampled; no error flag.
- Counter width: $clog2(WIDTH) bits. It never passes WIDTH-1; there is no wrap-around inside a word.
- Output decode:
  - `serial_out` = shift register MSB (MSB_FIRST=1) or LSB (MSB_FIRST=0) in SHIFT; 0 in IDLE.
  - `serial_valid` = 1 exactly in SHIFT.
  - `done` = SHIFT && counter == WIDTH-1.
- Reset mid-word (`rst` falls during SHIFT):
  - Immediate return to IDLE.
  - The in-flight word is dropped.
  - No `done` pulse.
- Reset values: state IDLE, counter 0, shift register 0, `serial_out` 0, `serial_valid` 0, `done` 0, `ready` 0 while in reset and 1 once `rst` = 1.

## Timing
- Accept at posedge k puts the first bit on `serial_out` in cycle k+1 (one-cycle latency).
- Bit i of the transmit order appears in cycle k+1+i, for i = 0..WIDTH-1.
- `done` = 1 in cycle k+WIDTH only.
- Throughput: one word per WIDTH cycles with `load` held high. `serial_valid` stays continuously 1.
- `ready`, `done` and `serial_valid` are all decoded from state and counter; none depend on `load` in the same cycle (no combinational input-to-output path).
- Reset assertion is asynchronous: outputs go to reset values immediately.
- Reset release must meet recovery to `clk`. The first accept is possible at the first posedge with `rst` = 1.

## Structure
- Shared package `piso_pkg`:
  - `typedef enum logic {IDLE, SHIFT} piso_state_t`.
  - Localparam helper for counter width (`CNT_W = $clog2(WIDTH)`).
- One sub-module is natural: `bit_counter`.
  - Parameterised up-counter with sync clear, enable and terminal-count flag (`tc` at WIDTH-1).
  - Reusable by a future serial receiver.
- Shift register and FSM stay in `piso_shifter`.

## Test plan
- Reset then single word: release `rst`, load 8'hA5 with MSB_FIRST=1.
  - Required: `serial_out` 1,0,1,0,0,1,0,1 in cycles k+1..k+8.
  - `serial_valid` high for exactly 8 cycles; `done` high only in cycle k+8; `ready` returns to 1 in cycle k+9.
- LSB order: MSB_FIRST=0, load 8'h01.
  - Required: bit sequence 1,0,0,0,0,0,0,0.
- Back-to-back: hold `load`=1 with 8'hF0 then 8'h0F presented on the last-bit cycle.
  - Required: 16 contiguous valid bits 11110000 00001111; two `done` pulses 8 cycles apart; no IDLE cycle between words.
- Busy load ignored: during cycle 3 of word 8'hC3, assert `load` with 8'hFF.
  - Required: the output stream is still 11000011, and 8'hFF is never transmitted.
- Reset mid-word: drop `rst` after 4 bits of 8'h3C.
  - Required: outputs go to 0 immediately; no `done`; after release `ready`=1; a new word 8'h81 transmits correctly.
- Randomised check: 50 random words through a bench-side deserializer.
  - Required: reconstructed words equal the words sent; error count 0.
